packet_assembler_crc: RTL and testbench
=======================================

Name: packet_assembler_crc

Overview:
Parametrised successor to the UART packet merger. It takes a received byte stream with a valid/ready handshake and optionally hunts for a sync byte. It assembles MESSAGE_LENGTH/8 payload bytes plus one trailing CRC-8 byte and checks the CRC internally with a configurable polynomial. Good packets go out on a valid/ready interface; CRC failures and inter-byte timeouts are flagged and counted. It sits between the UART receiver and the DAQ command decoder.

Parameters:
MESSAGE_LENGTH, 48, payload bits; must be a multiple of 8 and at least 8; SEG_COUNT = MESSAGE_LENGTH/8
CRC_POLY, 8'h07, CRC-8 polynomial: MSB-first, no reflection, no final XOR
CRC_INIT, 8'h00, CRC register value at the start of each packet
SYNC_EN, 1, 1 = discard bytes until SYNC_BYTE is seen; 0 = the first byte is payload
SYNC_BYTE, 8'hA5, start-of-packet marker; excluded from payload and CRC
TIMEOUT_CYCLES, 1000, maximum idle clk cycles between bytes inside a packet; must be at least 2
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_byte  in  8  received byte
i_byte_valid  in  1  i_byte is valid
o_byte_ready  out  1  block accepts a byte this cycle
o_packet  out  MESSAGE_LENGTH  assembled payload; byte k sits at bits [8k+7:8k]
o_packet_valid  out  1  o_packet holds a CRC-checked packet
i_packet_ready  in  1  consumer accepts o_packet
o_crc_error  out  1  one-cycle pulse on CRC mismatch
o_timeout_error  out  1  one-cycle pulse on inter-byte timeout
o_good_count  out  CNT_W  number of packets delivered; saturates at all-ones
o_err_count  out  CNT_W  number of CRC errors plus timeouts; saturates at all-ones

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state IDLE. o_packet, o_packet_valid, both error pulses, both counters and the internal segment counter are 0. o_byte_ready is 1 (IDLE is ready).
- Byte accept: a byte is accepted when i_byte_valid && o_byte_ready. o_byte_ready is 1 in IDLE and RECEIVE and 0 in CHECK and OUTPUT.
- State IDLE:
  - SYNC_EN=1: on an accepted byte equal to SYNC_BYTE, load crc=CRC_INIT, seg=0, timer=0 and go to RECEIVE. Any other byte is dropped silently.
  - SYNC_EN=0: the first accepted byte is payload byte 0. It is stored, crc is updated from CRC_INIT, seg=1, and the state goes to RECEIVE.
- State RECEIVE:
  - Accepted byte with seg<SEG_COUNT: store the byte at slot seg, fold it into crc (8 serial shift/XOR steps, combinational in one cycle), seg++, timer=0.
  - Accepted byte with seg==SEG_COUNT: this is the CRC byte. Latch it and go to CHECK.
  - No byte: timer++. When timer reaches TIMEOUT_CYCLES-1 with no byte that cycle:
    - pulse o_timeout_error and increment o_err_count;
    - discard the partial packet; o_packet keeps its old value;
    - go to IDLE.
  - A byte arriving in the timeout cycle wins: it is accepted and no error is raised.
- State CHECK (one cycle):
  - Received CRC == computed crc: copy the assembly buffer into o_packet, set o_packet_valid=1, go to OUTPUT.
  - Otherwise: pulse o_crc_error, increment o_err_count, go to IDLE. o_packet_valid stays 0.
  - Latency: CRC byte accepted in cycle N → o_packet_valid high in cycle N+2.
- State OUTPUT:
  - o_packet and o_packet_valid stay stable until i_packet_ready=1.
  - On that handshake: o_packet_valid=0 next cycle, o_good_count++, go to IDLE.
  - Upstream bytes are backpressured and no timeout runs in this state.
- Counters saturate at 2^CNT_W-1 and never wrap.
- o_packet holds the last good packet until the next one replaces it.
- Reset mid-packet or mid-OUTPUT drops everything and applies the reset values in the next cycle.
- A SYNC_BYTE value arriving inside RECEIVE is treated as ordinary data; there is no resync mid-packet.

Test Plan:
1. Defaults: A5, six bytes 00, CRC 00 → o_packet_valid at N+2, o_packet=48'h0, o_good_count=1 after handshake.
2. MESSAGE_LENGTH=72, SYNC_EN=0: bytes "123456789" (31..39) then F4 → o_packet=72'h393837363534333231 valid; same stream ending in F5 → o_crc_error one pulse, o_err_count=1, o_packet_valid never 1.
3. Defaults: bytes 11, 22 before A5, then a valid packet → leading bytes dropped, packet delivered correctly.
4. Defaults: A5, three payload bytes, then silence → o_timeout_error exactly 1000 idle cycles after the last byte. Next good packet delivered normally. Variant: a byte on cycle 999 → no timeout.
5. Backpressure: i_packet_ready=0 for 20 cycles while bytes are offered → o_byte_ready=0 and o_packet stable. Then ready=1 → one handshake, return to IDLE.
6. CNT_W=2: five good packets → o_good_count=3. Reset asserted mid-RECEIVE → all outputs return to reset values and the next packet is assembled from byte 0.

Source files
------------

// File: rtl/packet_assembler_crc.sv
// Packet assembler with CRC-8 check.
// Collects MESSAGE_LENGTH/8 payload bytes plus one trailing CRC byte from a
// byte stream, optionally after a sync byte. Packets that pass the check are
// presented on a valid/ready output. CRC failures and inter-byte timeouts
// raise a one-cycle pulse and are counted.
//
// Handshake semantics (both interfaces): a transfer happens on a rising clk
// edge where valid and ready are both 1. The producer holds data stable while
// valid is high and ready is low; the consumer may change ready freely.
module packet_assembler_crc #(
  parameter int       MESSAGE_LENGTH = 48,
  parameter logic [7:0] CRC_POLY     = 8'h07,
  parameter logic [7:0] CRC_INIT     = 8'h00,
  parameter bit       SYNC_EN        = 1'b1,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int       TIMEOUT_CYCLES = 1000,
  parameter int       CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                i_byte,
  input  logic                      i_byte_valid,
  output logic                      o_byte_ready,
  output logic [MESSAGE_LENGTH-1:0] o_packet,
  output logic                      o_packet_valid,
  input  logic                      i_packet_ready,
  output logic                      o_crc_error,
  output logic                      o_timeout_error,
  output logic [CNT_W-1:0]          o_good_count,
  output logic [CNT_W-1:0]          o_err_count
);

  localparam int SEG_COUNT = MESSAGE_LENGTH / 8;
  localparam int SEG_W     = $clog2(SEG_COUNT + 1);
  localparam int TMR_W     = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CHECK   = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t                    state;
  logic [SEG_W-1:0]          seg;
  logic [TMR_W-1:0]          timer;
  logic [7:0]                crc;
  logic [7:0]                crc_rx;
  logic [MESSAGE_LENGTH-1:0] buffer;

  logic       accept;
  logic [7:0] crc_next;
  logic [7:0] crc_first;

  // One byte folded into the CRC, MSB first, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Ready is a pure decode of the state register, so it never depends on valid.
  assign o_byte_ready = (state == IDLE) || (state == RECEIVE);
  assign accept       = i_byte_valid && o_byte_ready;
  assign crc_next     = crc8_byte(crc, i_byte);
  assign crc_first    = crc8_byte(CRC_INIT, i_byte);

  // Main FSM: assembly, CRC check, output hold, error pulses and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      seg             <= '0;
      timer           <= '0;
      crc             <= CRC_INIT;
      crc_rx          <= '0;
      buffer          <= '0;
      o_packet        <= '0;
      o_packet_valid  <= 1'b0;
      o_crc_error     <= 1'b0;
      o_timeout_error <= 1'b0;
      o_good_count    <= '0;
      o_err_count     <= '0;
    end else begin
      o_crc_error     <= 1'b0;
      o_timeout_error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (SYNC_EN) begin
              if (i_byte == SYNC_BYTE) begin
                crc   <= CRC_INIT;
                seg   <= '0;
                timer <= '0;
                state <= RECEIVE;
              end
            end else begin
              buffer[7:0] <= i_byte;
              crc         <= crc_first;
              seg         <= SEG_W'(1);
              timer       <= '0;
              state       <= RECEIVE;
            end
          end
        end
        RECEIVE: begin
          if (accept) begin
            timer <= '0;
            if (seg < SEG_W'(SEG_COUNT)) begin
              buffer[8*int'(seg) +: 8] <= i_byte;
              crc                      <= crc_next;
              seg                      <= seg + 1'b1;
            end else begin
              crc_rx <= i_byte;
              state  <= CHECK;
            end
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            // Partial packet is abandoned; o_packet keeps the last good one.
            o_timeout_error <= 1'b1;
            if (o_err_count != '1) o_err_count <= o_err_count + 1'b1;
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          if (crc_rx == crc) begin
            o_packet       <= buffer;
            o_packet_valid <= 1'b1;
            state          <= OUTPUT;
          end else begin
            o_crc_error <= 1'b1;
            if (o_err_count != '1) o_err_count <= o_err_count + 1'b1;
            state <= IDLE;
          end
        end
        OUTPUT: begin
          if (i_packet_ready) begin
            o_packet_valid <= 1'b0;
            if (o_good_count != '1) o_good_count <= o_good_count + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_assembler_crc.sv
// Directed bench for packet_assembler_crc: three instances cover the default
// configuration, a 72-bit no-sync configuration and 2-bit counters.
module tb_packet_assembler_crc;

  logic       clk;
  logic       reset;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       i_packet_ready;
  int         sel;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: defaults
  logic        a_valid, a_pready, a_byte_ready, a_packet_valid, a_crc_error, a_timeout_error;
  logic [47:0] a_packet;
  logic [15:0] a_good_count, a_err_count;
  // Instance B: 72-bit payload, no sync hunting
  logic        b_valid, b_pready, b_byte_ready, b_packet_valid, b_crc_error, b_timeout_error;
  logic [71:0] b_packet;
  logic [15:0] b_good_count, b_err_count;
  // Instance C: 2-bit counters
  logic        c_valid, c_pready, c_byte_ready, c_packet_valid, c_crc_error, c_timeout_error;
  logic [47:0] c_packet;
  logic [1:0]  c_good_count, c_err_count;

  assign a_valid  = i_byte_valid && (sel == 0);
  assign b_valid  = i_byte_valid && (sel == 1);
  assign c_valid  = i_byte_valid && (sel == 2);
  assign a_pready = i_packet_ready && (sel == 0);
  assign b_pready = i_packet_ready && (sel == 1);
  assign c_pready = i_packet_ready && (sel == 2);

  packet_assembler_crc u_dut_a (
    .clk(clk), .reset(reset), .i_byte(i_byte), .i_byte_valid(a_valid),
    .o_byte_ready(a_byte_ready), .o_packet(a_packet), .o_packet_valid(a_packet_valid),
    .i_packet_ready(a_pready), .o_crc_error(a_crc_error), .o_timeout_error(a_timeout_error),
    .o_good_count(a_good_count), .o_err_count(a_err_count)
  );

  packet_assembler_crc #(.MESSAGE_LENGTH(72), .SYNC_EN(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .i_byte(i_byte), .i_byte_valid(b_valid),
    .o_byte_ready(b_byte_ready), .o_packet(b_packet), .o_packet_valid(b_packet_valid),
    .i_packet_ready(b_pready), .o_crc_error(b_crc_error), .o_timeout_error(b_timeout_error),
    .o_good_count(b_good_count), .o_err_count(b_err_count)
  );

  packet_assembler_crc #(.CNT_W(2)) u_dut_c (
    .clk(clk), .reset(reset), .i_byte(i_byte), .i_byte_valid(c_valid),
    .o_byte_ready(c_byte_ready), .o_packet(c_packet), .o_packet_valid(c_packet_valid),
    .i_packet_ready(c_pready), .o_crc_error(c_crc_error), .o_timeout_error(c_timeout_error),
    .o_good_count(c_good_count), .o_err_count(c_err_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Event monitors
  int a_to_pulses    = 0;
  int b_valid_cycles = 0;
  always @(posedge clk) begin
    if (a_timeout_error) a_to_pulses <= a_to_pulses + 1;
    if (b_packet_valid)  b_valid_cycles <= b_valid_cycles + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_ready();
    case (sel)
      0:       return a_byte_ready;
      1:       return b_byte_ready;
      default: return c_byte_ready;
    endcase
  endfunction

  function automatic logic cur_valid();
    case (sel)
      0:       return a_packet_valid;
      1:       return b_packet_valid;
      default: return c_packet_valid;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one byte and return just after the edge that accepted it.
  task automatic send(input logic [7:0] b);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    i_byte       = b;
    i_byte_valid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = cur_ready();
      @(posedge clk);
      #1;
      guard++;
    end
    i_byte_valid = 1'b0;
    if (!acc) check("send_accept", 0, 1);
  endtask

  // Accept the presented packet and return just after the handshake edge.
  task automatic take_packet();
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    i_packet_ready = 1'b1;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = cur_valid();
      @(posedge clk);
      #1;
      guard++;
    end
    i_packet_ready = 1'b0;
    if (!acc) check("take_handshake", 0, 1);
  endtask

  // Sync byte, payload bytes b0..b5 (b0 first), CRC byte.
  task automatic send_pkt(input logic [47:0] p, input logic [7:0] c);
    send(8'hA5);
    for (int k = 0; k < 6; k++) send(p[8*k +: 8]);
    send(c);
  endtask

  logic [47:0] snap_a;
  int          snap_cnt;
  logic        bp_ready_bad;
  logic        bp_stable_bad;

  initial begin
    reset          = 1'b1;
    sel            = 0;
    i_byte         = 8'h00;
    i_byte_valid   = 1'b0;
    i_packet_ready = 1'b0;
    tick(3);
    check("rst_byte_ready", a_byte_ready, 1);
    check("rst_packet", a_packet, 0);
    check("rst_packet_valid", a_packet_valid, 0);
    check("rst_counts", {a_good_count, a_err_count}, 0);
    check("rst_err_pulses", {a_crc_error, a_timeout_error}, 0);
    reset = 1'b0;
    tick(1);

    // All-zero packet, latency N+2
    send_pkt(48'h0, 8'h00);
    check("zero_valid_n1", a_packet_valid, 0);
    tick(1);
    check("zero_valid_n2", a_packet_valid, 1);
    check("zero_packet", a_packet, 48'h0);
    take_packet();
    check("zero_valid_after", a_packet_valid, 0);
    check("zero_good", a_good_count, 1);

    // Leading junk dropped before sync; CRC of 00 00 00 00 01 02 is 1B
    send(8'h11);
    send(8'h22);
    send_pkt(48'h0201_0000_0000, 8'h1B);
    tick(1);
    check("junk_valid", a_packet_valid, 1);
    check("junk_packet", a_packet, 48'h0201_0000_0000);
    take_packet();
    check("junk_good", a_good_count, 2);

    // Sync byte value as payload data; CRC 25; then backpressure
    send_pkt(48'hA510_0000_0000, 8'h25);
    tick(1);
    check("syncdata_packet", a_packet, 48'hA510_0000_0000);
    bp_ready_bad  = 1'b0;
    bp_stable_bad = 1'b0;
    i_byte        = 8'h77;
    i_byte_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_byte_ready !== 1'b0) bp_ready_bad = 1'b1;
      if (a_packet !== 48'hA510_0000_0000 || a_packet_valid !== 1'b1) bp_stable_bad = 1'b1;
      @(posedge clk);
      #1;
    end
    i_byte_valid = 1'b0;
    check("bp_byte_ready_low", bp_ready_bad, 0);
    check("bp_packet_stable", bp_stable_bad, 0);
    check("bp_good_unchanged", a_good_count, 2);
    take_packet();
    check("bp_good", a_good_count, 3);
    check("bp_idle_ready", a_byte_ready, 1);

    // Inter-byte timeout after three payload bytes
    send(8'hA5);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    tick(999);
    check("to_not_yet", a_timeout_error, 0);
    tick(1);
    check("to_pulse", a_timeout_error, 1);
    check("to_err_count", a_err_count, 1);
    tick(1);
    check("to_pulse_end", a_timeout_error, 0);
    check("to_packet_kept", a_packet, 48'hA510_0000_0000);
    check("to_valid_low", a_packet_valid, 0);
    send_pkt(48'h0201_0000_0000, 8'h1B);
    tick(1);
    check("to_next_packet", a_packet, 48'h0201_0000_0000);
    take_packet();
    check("to_next_good", a_good_count, 4);

    // Byte in the timeout cycle wins
    snap_cnt = a_to_pulses;
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    tick(999);
    send(8'h00);
    send(8'h01);
    send(8'h02);
    send(8'h1B);
    tick(1);
    check("win_no_timeout", a_to_pulses - snap_cnt, 0);
    check("win_valid", a_packet_valid, 1);
    check("win_packet", a_packet, 48'h0201_0000_0000);
    check("win_err_count", a_err_count, 1);
    take_packet();
    check("win_good", a_good_count, 5);

    // CRC mismatch on default instance
    snap_a = a_packet;
    send_pkt(48'h0, 8'h01);
    tick(1);
    check("crcerr_pulse", a_crc_error, 1);
    check("crcerr_valid", a_packet_valid, 0);
    tick(1);
    check("crcerr_pulse_end", a_crc_error, 0);
    check("crcerr_count", a_err_count, 2);
    check("crcerr_packet_kept", a_packet, snap_a);

    // 72-bit, no sync: "123456789" has CRC F4
    sel = 1;
    for (int k = 0; k < 9; k++) send(8'h31 + 8'(k));
    send(8'hF4);
    check("b_valid_n1", b_packet_valid, 0);
    tick(1);
    check("b_valid_n2", b_packet_valid, 1);
    check("b_packet", b_packet, 72'h39_3837_3635_3433_3231);
    take_packet();
    check("b_good", b_good_count, 1);
    snap_cnt = b_valid_cycles;
    for (int k = 0; k < 9; k++) send(8'h31 + 8'(k));
    send(8'hF5);
    tick(1);
    check("b_crcerr_pulse", b_crc_error, 1);
    tick(1);
    check("b_crcerr_pulse_end", b_crc_error, 0);
    check("b_err_count", b_err_count, 1);
    tick(5);
    check("b_never_valid", b_valid_cycles - snap_cnt, 0);

    // 2-bit counters saturate; CRC of 00 00 00 00 00 FF is F3
    sel = 2;
    for (int n = 1; n <= 5; n++) begin
      send_pkt(48'hFF00_0000_0000, 8'hF3);
      tick(1);
      check("c_packet", c_packet, 48'hFF00_0000_0000);
      take_packet();
      check("c_good_sat", c_good_count, (n < 3) ? n : 3);
    end

    // Reset in OUTPUT, then reset mid-RECEIVE
    send_pkt(48'hFF00_0000_0000, 8'hF3);
    tick(1);
    check("c_output_valid", c_packet_valid, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("c_rst_out_valid", c_packet_valid, 0);
    check("c_rst_out_packet", c_packet, 0);
    check("c_rst_out_good", c_good_count, 0);
    send(8'hA5);
    send(8'h11);
    send(8'h22);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("c_rst_rx_ready", c_byte_ready, 1);
    check("c_rst_rx_counts", {c_good_count, c_err_count}, 0);
    check("c_rst_rx_pulses", {c_crc_error, c_timeout_error, c_packet_valid}, 0);
    send_pkt(48'h0201_0000_0000, 8'h1B);
    tick(1);
    check("c_after_rst_valid", c_packet_valid, 1);
    check("c_after_rst_packet", c_packet, 48'h0201_0000_0000);
    take_packet();
    check("c_after_rst_good", c_good_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
